decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, 32, datapath and immediate width (32 or 64).
REQ-002 Parameter ALU_CTL_W, 5, alu_ctl width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  drop all held instructions.
REQ-006 in_valid / in_ready  input / output  1 / 1  fetch-side handshake.
REQ-007 in_pc, in_instr  input  XLEN, 32  fetched PC and raw instruction.
REQ-008 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-009 out_pc, imm  output  XLEN, XLEN  PC and sign-extended immediate.
REQ-010 alu_ctl  output  ALU_CTL_W  ALU operation code.
REQ-011 branch_c, branch_uc, mem_read, mem_write, alu_src, reg_write, illegal  output  1 each  control flags.
REQ-012 mem_size, br_cond  output  3, 3  funct3 of load/store and of branch.
REQ-013 read_reg1, read_reg2, write_reg  output  5 each  rs1, rs2, rd of the presented instruction.

Function
REQ-014 Transfer occurs on a cycle where valid and ready are both high; in_ready and out_valid are driven directly from flops only.
REQ-015 Storage is a 2-entry skid buffer: main register drives outputs, skid register catches one instruction when out_ready drops.
REQ-016 States: EMPTY (no entry), ONE (main valid), FULL (main + skid valid); in_ready = (state != FULL); out_valid = (state != EMPTY).
REQ-017 EMPTY: input accepted -> ONE, decode into main.
REQ-018 ONE: accept without output transfer -> FULL (decode into skid); output transfer without accept -> EMPTY; both -> ONE, main reloaded with new decode; neither -> hold.
REQ-019 FULL: output transfer -> ONE, skid moves into main; otherwise hold; no input accepted.
REQ-020 Latency: instruction accepted at edge N is presented at out_* after edge N when buffer was EMPTY or drained same cycle; throughput one per cycle with out_ready held high.
REQ-021 Presented outputs stay stable while out_valid=1 and out_ready=0.
REQ-022 flush=1 at an edge -> state EMPTY, in_instr that cycle discarded; flush has priority over both handshakes.
REQ-023 Decode (RV32I): R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111 (funct3 000), LUI 0110111, AUIPC 0010111.
REQ-024 Immediates sign-extended from bit 31 to XLEN: I, S, B (bit0=0), J (bit0=0, sign-extended), U (instr[31:12]<<12).
REQ-025 alu_ctl: ADD 2 (addi, add, load, store, jalr, auipc), SUB 6, AND 0, OR 1, XOR 3, SLL 4, SRL 5, SRA 7, SLT 9, SLTU 11, BRANCH-compare 8, CHOOSEB 10 (jal, lui), ZERO 31.
REQ-026 alu_src=1 for I-ALU, LOAD, STORE, JALR, LUI, AUIPC; 0 otherwise.
REQ-027 branch_c=1 for BRANCH; branch_uc=1 for JAL/JALR; mem_read for LOAD; mem_write for STORE.
REQ-028 reg_write=1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC, forced 0 when rd=0.
REQ-029 illegal=1 for unlisted opcode, BRANCH funct3 010/011, LOAD funct3 011/110/111, STORE funct3 >010, R funct7 not 0000000/0100000, SUB/SRA funct7 on other funct3; when illegal, all other control flags 0 and alu_ctl=31.
REQ-030 All outputs are flop outputs; decode is evaluated at the input edge, not at output.

Reset
REQ-031 rst_n=0 -> state EMPTY immediately; out_valid=0, in_ready=1, all payload/control outputs 0, alu_ctl=31.
REQ-032 Reset mid-transfer discards both entries; first edge after release accepts normally.

Verification
REQ-033 add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_ctl=2, reg_write=1, write_reg=3, alu_src=0.
REQ-034 Stream of 3 instrs, out_ready low 1 cycle after first accept -> state FULL, in_ready=0, no loss, order preserved.
REQ-035 jal x1,-4 (0xFFDFF0EF), XLEN=64 -> imm=0xFFFF_FFFF_FFFF_FFFC, branch_uc=1, alu_ctl=10.
REQ-036 addi x0,x0,5 -> reg_write=0; opcode 0x7F -> illegal=1, alu_ctl=31, mem_write=0.
REQ-037 flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1.
REQ-038 rst_n low while FULL -> out_valid=0 without a clock edge.

Source files
------------

// File: rtl/decode_pipe.sv
// RV32I decode stage behind a 2-entry skid buffer. The instruction is decoded as it is accepted.
// The main register drives all outputs. The skid register holds one extra entry while the consumer stalls.
module decode_pipe #(
  parameter int XLEN      = 32,
  parameter int ALU_CTL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      imm,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 branch_c,
  output logic                 branch_uc,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [2:0]           mem_size,
  output logic [2:0]           br_cond,
  output logic [4:0]           read_reg1,
  output logic [4:0]           read_reg2,
  output logic [4:0]           write_reg,
  output logic [1:0]           dbg_state
);

  localparam logic [ALU_CTL_W-1:0] ALU_AND  = ALU_CTL_W'(0);
  localparam logic [ALU_CTL_W-1:0] ALU_OR   = ALU_CTL_W'(1);
  localparam logic [ALU_CTL_W-1:0] ALU_ADD  = ALU_CTL_W'(2);
  localparam logic [ALU_CTL_W-1:0] ALU_XOR  = ALU_CTL_W'(3);
  localparam logic [ALU_CTL_W-1:0] ALU_SLL  = ALU_CTL_W'(4);
  localparam logic [ALU_CTL_W-1:0] ALU_SRL  = ALU_CTL_W'(5);
  localparam logic [ALU_CTL_W-1:0] ALU_SUB  = ALU_CTL_W'(6);
  localparam logic [ALU_CTL_W-1:0] ALU_SRA  = ALU_CTL_W'(7);
  localparam logic [ALU_CTL_W-1:0] ALU_BR   = ALU_CTL_W'(8);
  localparam logic [ALU_CTL_W-1:0] ALU_SLT  = ALU_CTL_W'(9);
  localparam logic [ALU_CTL_W-1:0] ALU_CHB  = ALU_CTL_W'(10);
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU = ALU_CTL_W'(11);
  localparam logic [ALU_CTL_W-1:0] ALU_ZERO = ALU_CTL_W'(31);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic                 branch_c;
    logic                 branch_uc;
    logic                 mem_read;
    logic                 mem_write;
    logic                 alu_src;
    logic                 reg_write;
    logic                 illegal;
    logic [2:0]           mem_size;
    logic [2:0]           br_cond;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
  } dec_t;

  // Base (funct7 = 0) operation selected by funct3, shared by R and I-ALU forms.
  function automatic logic [ALU_CTL_W-1:0] f3_alu(input logic [2:0] f3);
    logic [ALU_CTL_W-1:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  state_t    r_state;
  state_t    w_state_nxt;
  logic      r_in_ready;
  logic      r_out_valid;
  dec_t      r_main;
  dec_t      r_skid;
  dec_t      w_dec;
  logic      w_ill;
  logic      w_in_fire;
  logic      w_out_fire;
  logic      w_ld_main_dec;
  logic      w_ld_main_skid;
  logic      w_ld_skid;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];

  always_comb begin
    w_dec         = '0;
    w_ill         = 1'b0;
    w_dec.alu_ctl = ALU_ZERO;
    w_dec.pc      = in_pc;
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.rd      = in_instr[11:7];
    case (w_opcode)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        if (w_f7 == F7_BASE)                       w_dec.alu_ctl = f3_alu(w_f3);
        else if (w_f7 == F7_ALT && w_f3 == 3'b000) w_dec.alu_ctl = ALU_SUB;
        else if (w_f7 == F7_ALT && w_f3 == 3'b101) w_dec.alu_ctl = ALU_SRA;
        else                                       w_ill = 1'b1;
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.imm       = XLEN'($signed(in_instr[31:20]));
        w_dec.alu_ctl   = f3_alu(w_f3);
        // Shift-immediates carry funct7 in the upper immediate bits.
        if (w_f3 == 3'b001 && w_f7 != F7_BASE) w_ill = 1'b1;
        if (w_f3 == 3'b101) begin
          if (w_f7 == F7_ALT)        w_dec.alu_ctl = ALU_SRA;
          else if (w_f7 != F7_BASE)  w_ill = 1'b1;
        end
      end
      OP_LOAD: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_read  = 1'b1;
        w_dec.alu_ctl   = ALU_ADD;
        w_dec.mem_size  = w_f3;
        w_dec.imm       = XLEN'($signed(in_instr[31:20]));
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
      end
      OP_STORE: begin
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.alu_ctl   = ALU_ADD;
        w_dec.mem_size  = w_f3;
        w_dec.imm       = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
        if (w_f3 > 3'b010) w_ill = 1'b1;
      end
      OP_BR: begin
        w_dec.branch_c = 1'b1;
        w_dec.alu_ctl  = ALU_BR;
        w_dec.br_cond  = w_f3;
        w_dec.imm      = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                        in_instr[11:8], 1'b0}));
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
      end
      OP_JAL: begin
        w_dec.branch_uc = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_ctl   = ALU_CHB;
        w_dec.imm       = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
      end
      OP_JALR: begin
        w_dec.branch_uc = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctl   = ALU_ADD;
        w_dec.imm       = XLEN'($signed(in_instr[31:20]));
        if (w_f3 != 3'b000) w_ill = 1'b1;
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctl   = ALU_CHB;
        w_dec.imm       = XLEN'($signed({in_instr[31:12], 12'h000}));
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctl   = ALU_ADD;
        w_dec.imm       = XLEN'($signed({in_instr[31:12], 12'h000}));
      end
      default: w_ill = 1'b1;
    endcase
    // An illegal instruction must not cause any side effect downstream.
    if (w_ill) begin
      w_dec.imm       = '0;
      w_dec.alu_ctl   = ALU_ZERO;
      w_dec.branch_c  = 1'b0;
      w_dec.branch_uc = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.alu_src   = 1'b0;
      w_dec.reg_write = 1'b0;
      w_dec.mem_size  = 3'b000;
      w_dec.br_cond   = 3'b000;
      w_dec.illegal   = 1'b1;
    end
    if (w_dec.rd == 5'd0) w_dec.reg_write = 1'b0;
  end

  // Handshake: a beat moves on an edge where valid and ready are both high. in_ready and
  // out_valid come from flops. A producer holds valid and payload stable until it is accepted.
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_dec  = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt   = S_ONE;
            w_ld_main_dec = 1'b1;
          end
        end
        S_ONE: begin
          case ({w_in_fire, w_out_fire})
            2'b11:   w_ld_main_dec = 1'b1;
            2'b10: begin
              w_state_nxt = S_FULL;
              w_ld_skid   = 1'b1;
            end
            2'b01:   w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_ONE;
          endcase
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt    = S_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_EMPTY;
      r_in_ready       <= 1'b1;
      r_out_valid      <= 1'b0;
      r_main           <= '0;
      r_main.alu_ctl   <= ALU_ZERO;
      r_skid           <= '0;
      r_skid.alu_ctl   <= ALU_ZERO;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_ld_main_dec)       r_main <= w_dec;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= w_dec;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dbg_state = r_state;
  assign out_pc    = r_main.pc;
  assign imm       = r_main.imm;
  assign alu_ctl   = r_main.alu_ctl;
  assign branch_c  = r_main.branch_c;
  assign branch_uc = r_main.branch_uc;
  assign mem_read  = r_main.mem_read;
  assign mem_write = r_main.mem_write;
  assign alu_src   = r_main.alu_src;
  assign reg_write = r_main.reg_write;
  assign illegal   = r_main.illegal;
  assign mem_size  = r_main.mem_size;
  assign br_cond   = r_main.br_cond;
  assign read_reg1 = r_main.rs1;
  assign read_reg2 = r_main.rs2;
  assign write_reg = r_main.rd;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe at XLEN=64. It uses a decode vector table and skid/flush/reset
// sequences, and checks transfer order with a PC scoreboard.
module tb_decode_pipe;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] imm;
  logic [AW-1:0]   alu_ctl;
  logic            branch_c, branch_uc, mem_read, mem_write, alu_src, reg_write, illegal;
  logic [2:0]      mem_size, br_cond;
  logic [4:0]      read_reg1, read_reg2, write_reg;
  logic [1:0]      dbg_state;

  decode_pipe #(.XLEN(XLEN), .ALU_CTL_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .imm(imm),
    .alu_ctl(alu_ctl), .branch_c(branch_c), .branch_uc(branch_uc), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .illegal(illegal),
    .mem_size(mem_size), .br_cond(br_cond), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags order: {branch_c, branch_uc, mem_read, mem_write, alu_src, reg_write, illegal}
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  alu;
    logic [6:0]  flags;
    logic [2:0]  msz;
    logic [2:0]  brc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [4:0]  alu;
    logic [6:0]  flags;
    logic [2:0]  msz;
    logic [2:0]  brc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;
  logic        sb_en = 1'b0;

  function automatic out_t get_out();
    out_t o;
    o = {out_pc, imm, alu_ctl,
         {branch_c, branch_uc, mem_read, mem_write, alu_src, reg_write, illegal},
         mem_size, br_cond, read_reg1, read_reg2, write_reg};
    return o;
  endfunction

  function automatic out_t vec_exp(input int i, input logic [63:0] pc);
    out_t o;
    o = {pc, vecs[i].imm, vecs[i].alu, vecs[i].flags, vecs[i].msz, vecs[i].brc,
         vecs[i].rs1, vecs[i].rs2, vecs[i].rd};
    return o;
  endfunction

  function automatic out_t reset_exp();
    out_t o;
    o     = '0;
    o.alu = 5'd31;
    return o;
  endfunction

  // scoreboard
  task automatic check_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PC order monitor: inputs are driven just after posedge, so negedge sees stable handshakes.
  always @(negedge clk) begin
    if (sb_en) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: got pc %h expected no transfer", out_pc);
        end else begin
          sb_exp = exp_q.pop_front();
          if (out_pc !== sb_exp) begin
            failures++;
            $display("FAIL sb_order: got pc %h expected %h", out_pc, sb_exp);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_pc);
    end
  end

  // drivers
  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT FULL: main = instr at pc, skid = instr at pc+4; inputs idle afterwards.
  task automatic fill_full(input logic [63:0] pc);
    drive(1'b1, pc, 32'h002081B3, 1'b1);
    step();
    drive(1'b1, pc + 64'd4, 32'h407302B3, 1'b0);
    step();
    drive(1'b0, 64'd0, 32'd0, 1'b0);
    check_val("fill_full_state", {62'd0, dbg_state}, 64'd2);
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 64'h0,                  5'd2,  7'b0000010, 3'd0, 3'd0, 5'd1,  5'd2,  5'd3};
    vecs[1]  = '{32'h407302B3, 64'h0,                  5'd6,  7'b0000010, 3'd0, 3'd0, 5'd6,  5'd7,  5'd5};
    vecs[2]  = '{32'h00500013, 64'h5,                  5'd2,  7'b0000100, 3'd0, 3'd0, 5'd0,  5'd5,  5'd0};
    vecs[3]  = '{32'h0000007F, 64'h0,                  5'd31, 7'b0000001, 3'd0, 3'd0, 5'd0,  5'd0,  5'd0};
    vecs[4]  = '{32'hFFDFF0EF, 64'hFFFFFFFFFFFFFFFC,   5'd10, 7'b0100010, 3'd0, 3'd0, 5'd31, 5'd29, 5'd1};
    vecs[5]  = '{32'hFF812203, 64'hFFFFFFFFFFFFFFF8,   5'd2,  7'b0010110, 3'd2, 3'd0, 5'd2,  5'd24, 5'd4};
    vecs[6]  = '{32'h00532623, 64'hC,                  5'd2,  7'b0001100, 3'd2, 3'd0, 5'd6,  5'd5,  5'd12};
    vecs[7]  = '{32'hFE209CE3, 64'hFFFFFFFFFFFFFFF8,   5'd8,  7'b1000000, 3'd0, 3'd1, 5'd1,  5'd2,  5'd25};
    vecs[8]  = '{32'h800003B7, 64'hFFFFFFFF80000000,   5'd10, 7'b0000110, 3'd0, 3'd0, 5'd0,  5'd0,  5'd7};
    vecs[9]  = '{32'h00002063, 64'h0,                  5'd31, 7'b0000001, 3'd0, 3'd0, 5'd0,  5'd0,  5'd0};
    vecs[10] = '{32'h40315093, 64'h403,                5'd7,  7'b0000110, 3'd0, 3'd0, 5'd2,  5'd3,  5'd1};
    vecs[11] = '{32'h40001033, 64'h0,                  5'd31, 7'b0000001, 3'd0, 3'd0, 5'd0,  5'd0,  5'd0};
    vecs[12] = '{32'h00001517, 64'h1000,               5'd2,  7'b0000110, 3'd0, 3'd0, 5'd0,  5'd0,  5'd10};
    vecs[13] = '{32'h000280E7, 64'h0,                  5'd2,  7'b0100110, 3'd0, 3'd0, 5'd5,  5'd0,  5'd1};
    vecs[14] = '{32'h00003003, 64'h0,                  5'd31, 7'b0000001, 3'd0, 3'd0, 5'd0,  5'd0,  5'd0};
    vecs[15] = '{32'h00A4C433, 64'h0,                  5'd3,  7'b0000010, 3'd0, 3'd0, 5'd9,  5'd10, 5'd8};

    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 64'd0, 32'd0, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_out("rst_payload", get_out(), reset_exp());
    repeat (2) step();
    rst_n = 1'b1;
    check_val("rst_state", {62'd0, dbg_state}, 64'd0);

    // Back-to-back decode stream: each instruction is presented right after its accept edge.
    drive(1'b1, 64'h1000, vecs[0].instr, 1'b1);
    for (int i = 0; i < NV; i++) begin
      step();
      check_val($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check_out($sformatf("vec%0d", i), get_out(), vec_exp(i, 64'h1000 + 64'(4 * i)));
      if (i < NV - 1) drive(1'b1, 64'h1000 + 64'(4 * (i + 1)), vecs[i + 1].instr, 1'b1);
      else            drive(1'b0, 64'd0, 32'd0, 1'b1);
    end
    step();
    check_val("drain_valid", {63'd0, out_valid}, 64'd0);

    // Stall while ONE: presented outputs hold.
    drive(1'b1, 64'h3000, vecs[4].instr, 1'b1);
    step();
    drive(1'b0, 64'd0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("hold%0d", k), get_out(), vec_exp(4, 64'h3000));
    end
    check_val("jal_imm", imm, 64'hFFFFFFFFFFFFFFFC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Three-instruction stream with a one-cycle stall: FULL, no loss, order preserved.
    sb_en = 1'b1;
    drive(1'b1, 64'h2000, vecs[0].instr, 1'b1);
    step();
    drive(1'b1, 64'h2004, vecs[1].instr, 1'b0);
    step();
    check_val("full_state", {62'd0, dbg_state}, 64'd2);
    check_val("full_in_ready", {63'd0, in_ready}, 64'd0);
    check_out("full_main_stable", get_out(), vec_exp(0, 64'h2000));
    drive(1'b1, 64'h2008, vecs[15].instr, 1'b1);
    step();
    check_out("skid_to_main", get_out(), vec_exp(1, 64'h2004));
    check_val("after_full_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    check_out("third_instr", get_out(), vec_exp(15, 64'h2008));
    drive(1'b0, 64'd0, 32'd0, 1'b1);
    step();
    sb_en = 1'b0;
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    check_val("stream_drained", {62'd0, dbg_state}, 64'd0);

    // Flush in FULL beats both handshakes; the instruction offered that cycle is dropped.
    fill_full(64'h5000);
    flush = 1'b1;
    drive(1'b1, 64'h5008, vecs[2].instr, 1'b1);
    step();
    flush = 1'b0;
    check_val("flush_full_valid", {63'd0, out_valid}, 64'd0);
    check_val("flush_full_ready", {63'd0, in_ready}, 64'd1);
    check_val("flush_full_state", {62'd0, dbg_state}, 64'd0);
    drive(1'b0, 64'd0, 32'd0, 1'b1);
    step();
    check_val("flush_discard", {63'd0, out_valid}, 64'd0);

    // Flush in ONE with both handshakes active.
    drive(1'b1, 64'h6000, vecs[0].instr, 1'b1);
    step();
    flush = 1'b1;
    drive(1'b1, 64'h6004, vecs[1].instr, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 64'd0, 32'd0, 1'b0);
    check_val("flush_one_state", {62'd0, dbg_state}, 64'd0);

    // Asynchronous reset while FULL, then normal accept on the first edge.
    fill_full(64'h7000);
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", {63'd0, out_valid}, 64'd0);
    check_val("arst_ready", {63'd0, in_ready}, 64'd1);
    check_out("arst_payload", get_out(), reset_exp());
    #1 rst_n = 1'b1;
    drive(1'b1, 64'h4000, vecs[5].instr, 1'b1);
    step();
    check_val("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check_out("post_rst_payload", get_out(), vec_exp(5, 64'h4000));
    drive(1'b0, 64'd0, 32'd0, 1'b1);
    step();
    check_val("post_rst_drain", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
